// File: rtl/core_scheduler.sv
// core_scheduler: per-core block scheduler FSM.
// Handles block start, instruction fetch, the LSU handshake and PC update,
// then holds done until the dispatcher resets the core.
// Optional feature macro: WAIT_TIMEOUT_EN adds a watchdog that aborts a stuck WAIT
// after 256 cycles and raises error. Without the macro WAIT never times out
// and error is tied low.
module core_scheduler (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  block_id,
   input  logic [2:0]  thread_count,
   output logic        done,
   output logic [3:0]  thread_enable,
   output logic [7:0]  block_id_q,
   output logic [2:0]  core_state,
   output logic [7:0]  pc,
   output logic        instr_req,
   output logic [7:0]  instr_addr,
   input  logic        instr_valid,
   input  logic [15:0] instr_data,
   output logic [15:0] instruction,
   input  logic        mem_op,
   input  logic        ret,
   output logic        lsu_req,
   input  logic [3:0]  lsu_done,
   input  logic [7:0]  next_pc,
   output logic        error
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_REQUEST = 3'd3,
      S_WAIT    = 3'd4,
      S_EXECUTE = 3'd5,
      S_UPDATE  = 3'd6,
      S_DONE    = 3'd7
   } state_t;

   state_t state;
   state_t state_nx;
   logic   wait_exit;
   logic   timeout_hit;

   // Thread counts above the core width saturate to all four lanes.
   function automatic logic [3:0] enable_mask(input logic [2:0] count);
      logic [3:0] mask;
      case (count)
         3'd0:    mask = 4'b0000;
         3'd1:    mask = 4'b0001;
         3'd2:    mask = 4'b0011;
         3'd3:    mask = 4'b0111;
         default: mask = 4'b1111;
      endcase
      return mask;
   endfunction

   assign core_state = state;
   assign instr_addr = pc;

   // A WAIT can leave once the instruction needs no memory access or every enabled lane has completed;
   // with no lanes enabled the mask compare is trivially true.
   assign wait_exit = !mem_op || ((lsu_done & thread_enable) == thread_enable);

`ifdef WAIT_TIMEOUT_EN
   logic [7:0] wait_cnt;

   assign timeout_hit = (state == S_WAIT) && !wait_exit && (wait_cnt == 8'hFF);

   // Watchdog: counts cycles spent in WAIT, zero on every WAIT entry; error is sticky.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= 8'd0;
         error    <= 1'b0;
      end else begin
         if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
         end else begin
            wait_cnt <= 8'd0;
         end
         if (timeout_hit) begin
            error <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign error       = 1'b0;
`endif

   // Next-state and combinational request outputs.
   always_comb begin
      state_nx  = state;
      instr_req = 1'b0;
      lsu_req   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_FETCH;
            end
         end
         S_FETCH: begin
            instr_req = 1'b1;
            if (instr_valid) begin
               state_nx = S_DECODE;
            end
         end
         S_DECODE: begin
            state_nx = S_REQUEST;
         end
         S_REQUEST: begin
            lsu_req  = mem_op;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (wait_exit) begin
               state_nx = S_EXECUTE;
            end else if (timeout_hit) begin
               state_nx = S_DONE;
            end
         end
         S_EXECUTE: begin
            state_nx = S_UPDATE;
         end
         S_UPDATE: begin
            state_nx = ret ? S_DONE : S_FETCH;
         end
         default: begin
            state_nx = S_DONE;
         end
      endcase
   end

   // State register plus the block context, PC, instruction latch and done flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         pc            <= 8'd0;
         done          <= 1'b0;
         instruction   <= 16'd0;
         block_id_q    <= 8'd0;
         thread_enable <= 4'b0000;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: begin
               if (start) begin
                  pc            <= 8'd0;
                  block_id_q    <= block_id;
                  thread_enable <= enable_mask(thread_count);
               end
            end
            S_FETCH: begin
               if (instr_valid) begin
                  instruction <= instr_data;
               end
            end
            S_UPDATE: begin
               if (!ret) begin
                  pc <= next_pc;
               end
            end
            default: begin
            end
         endcase
         if (state_nx == S_DONE) begin
            done <= 1'b1;
         end
      end
   end

endmodule
